// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, access-size
// encodings and the memory response code.
package ysyx_24110015_lsu_pkg;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_WAIT = 2'd2;
    localparam lsu_state_t ST_RESP = 2'd3;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Combinational lane logic: store data shift and strobes, misalignment/illegal
// size detection, and load byte/halfword extraction with extension.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        st_bad,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_wdata = st_data << {st_off, 3'b000};
        st_wstrb = 4'b0000;
        st_bad   = 1'b1;
        case (st_funct3)
            LS_B, LS_BU: begin
                st_wstrb = 4'b0001 << st_off;
                st_bad   = 1'b0;
            end
            LS_H, LS_HU: begin
                st_wstrb = 4'b0011 << st_off;
                st_bad   = st_off[0];
            end
            LS_W: begin
                st_wstrb = 4'b1111;
                st_bad   = |st_off;
            end
            default: st_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_data  = 32'h0;
        case (ld_funct3)
            LS_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LS_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LS_W:    ld_data = ld_raw;
            LS_BU:   ld_data = {24'h0, ld_shift[7:0]};
            LS_HU:   ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: accepts one core request, issues a single-cycle SRAM request,
// waits for the response (with timeout) and returns the result to the core.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    output logic [3:0]            wstrb,
    input  logic [1:0]            bresp,
    input  logic                  bvalid
);

    localparam int         CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    lsu_state_t  state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [CW-1:0] cnt;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        st_bad;
    logic [31:0] ld_data;
    logic        rsp_hit;
    logic [1:0]  rsp_code;

    ysyx_24110015_lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .st_bad    (st_bad),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_raw    (rdata),
        .ld_data   (ld_data)
    );

    // Only the valid that matches the outstanding access type counts.
    assign rsp_hit    = store_q ? bvalid : rvalid;
    assign rsp_code   = store_q ? bresp : rresp;
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            cnt        <= '0;
            ren        <= 1'b0;
            wen        <= 1'b0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            wstrb      <= 4'b0000;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        cnt      <= '0;
                        if (st_bad) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            ren <= ~req_store;
                            wen <= req_store;
                            if (req_store) begin
                                awaddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                                wdata  <= st_wdata;
                                wstrb  <= st_wstrb;
                            end else begin
                                araddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            end
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    ren   <= 1'b0;
                    wen   <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response arriving on the last allowed cycle still wins.
                    if (rsp_hit) begin
                        resp_err   <= (rsp_code != RESP_OKAY);
                        resp_rdata <= store_q ? '0 : ld_data;
                        state      <= ST_RESP;
                    end else if (cnt == TO_MAX) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_24110015_lsu.md
# ysyx_24110015_lsu

Load/store unit: the initiator side of the core's simple memory request interface. It accepts one load or store from the execute stage, drives a single-cycle `ren`/`wen` request to the SRAM responder, and waits for `rvalid`/`bvalid`. It returns sign- or zero-extended load data, or store completion, to the core through a valid/ready handshake. It also handles sub-word alignment, write-strobe generation, misalignment detection and a response timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT, 255, maximum number of cycles spent in WAIT before an error response is forced.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size and extension: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  result is available to the core.
- resp_ready  in  1  core accepts the result.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access, bad funct3, nonzero rresp/bresp, or timeout.
- araddr  out  32  word-aligned read address.
- ren  out  1  read request pulse.
- rdata  in  32  read data from the responder.
- rresp  in  2  read response; 00 = OKAY.
- rvalid  in  1  read response valid.
- awaddr  out  32  word-aligned write address.
- wdata  out  32  lane-shifted store data.
- wen  out  1  write request pulse.
- wstrb  out  4  byte-lane strobe.
- bresp  in  2  write response; 00 = OKAY.
- bvalid  in  1  write response valid.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the LSU registers store, funct3, addr and wdata.
  - If the access is misaligned (H with addr[0]=1, W with addr[1:0]≠0) or funct3 is illegal, the LSU goes directly to RESP with err=1. No memory request is issued.
  - Otherwise the LSU goes to REQ.
- REQ:
  - Drives `ren`=1 (load) or `wen`=1 (store) for exactly one cycle, then goes to WAIT.
  - araddr/awaddr = {addr[31:2],2'b00}.
  - wdata = req_wdata << (8·addr[1:0]).
  - wstrb = {0001 for B, 0011 for H, 1111 for W} << addr[1:0].
- WAIT:
  - Loads sample only `rvalid`; stores sample only `bvalid`. The other valid input is ignored.
  - On a response, the LSU captures the data and `resp_err` = (rresp/bresp ≠ 00), then goes to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT, the LSU goes to RESP with err=1 and rdata=0.
- RESP:
  - `resp_valid`=1, with `resp_rdata`/`resp_err` held stable until `resp_ready`. Then the LSU returns to IDLE.
- Load extraction: byte = rdata >> (8·addr[1:0]).
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- rvalid/bvalid seen outside WAIT are ignored.
- Reset mid-operation returns the FSM to IDLE, drops any in-flight response, and clears the counter.

## Timing
- Reset values:
  - req_ready=1.
  - ren=0, wen=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - araddr=0, awaddr=0, wdata=0, wstrb=0.
- Accept at cycle T, `ren`/`wen` high at T+1, WAIT from T+2.
- A 1-cycle responder asserts valid in T+2, so `resp_valid` rises at T+3. Minimum request-to-response latency is 3 cycles.
- Misaligned request: `resp_valid` at T+1; `ren`/`wen` never assert.
- `req_ready`=0 in REQ, WAIT and RESP. There is at most one outstanding transaction.
- Timeout: resp_valid at T+2+TIMEOUT+1 if no response arrives.
- `resp_ready` held low: RESP is held indefinitely with all outputs stable.
- Request outputs are registered; `ren`/`wen` never assert for more than one cycle per transaction.

## Structure
- Shared package `ysyx_24110015_lsu_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, RESP);
  - funct3 constants (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - the response code RESP_OKAY=2'b00.
- Sub-module `ysyx_24110015_lsu_align` (combinational) covers store shift/strobe generation, load extraction/extension, and the misalignment check.
- The top level holds the FSM, registers and timeout counter.

## Test plan
- LW addr=0x8000_0004, rdata=0xDEAD_BEEF after 1 cycle -> araddr=0x8000_0004, ren pulse 1 cycle, resp_rdata=0xDEAD_BEEF, err=0, resp_valid at T+3.
- LB addr=0x8000_0003, rdata=0x80xx_xxxx -> resp_rdata=0xFFFF_FF80; LBU same access -> 0x0000_0080.
- SH addr=0x8000_0002, wdata=0x1234 -> awaddr=0x8000_0000, wdata=0x1234_0000, wstrb=1100, wen 1 cycle; bvalid -> resp_valid, err=0.
- LH addr=0x8000_0001 -> resp_err=1 at T+1, ren never asserted; funct3=011 -> err=1.
- LW, responder silent, TIMEOUT=8 -> resp_err=1, rdata=0 at T+11; a later stray rvalid in IDLE is ignored.
- rst asserted in WAIT -> all outputs at reset values immediately; next LW completes normally. Also: resp_ready held low 5 cycles -> outputs stable, req_ready=0.
